// File: rtl/rca_slice_sequencer.sv
// Multi-cycle adder: one SLICE-bit ripple-carry slice reused over WIDTH bits, LSB slice first.
// Latency: done is visible N = WIDTH/SLICE edges after the start-accepting edge.
// Flow control: start is sampled only in IDLE; start in RUN/DONE is dropped, not queued.
module rca_slice_sequencer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [KW-1:0]    k;
  logic             carry;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] partial, partial_next;
  logic [SLICE:0]   slice_res;
  logic             last;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and status outputs; busy and done decode disjoint states.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shared slice adder and the partial word with the current slice merged in.
  always_comb begin
    slice_res    = {1'b0, op_a[k*SLICE +: SLICE]} + {1'b0, op_b[k*SLICE +: SLICE]}
                 + {{SLICE{1'b0}}, carry};
    partial_next = partial;
    partial_next[k*SLICE +: SLICE] = slice_res[SLICE-1:0];
    last         = (k == KW'(N - 1));
  end

  // Operand capture, per-slice accumulation, and atomic result load on the last slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      carry   <= 1'b0;
      k       <= '0;
      partial <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_a    <= a;
            op_b    <= b;
            carry   <= cin;
            k       <= '0;
            partial <= '0;
          end
        end
        RUN: begin
          partial <= partial_next;
          carry   <= slice_res[SLICE];
          k       <= k + KW'(1);
          if (last) begin
            sum  <= partial_next;
            cout <= slice_res[SLICE];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
